// File: rtl/gpu_arb_pkg.sv
// Shared arbiter state encoding for the GPU op arbiter.
package gpu_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/gpu_op_t.sv
// Shared GPU draw-op payload carried from requesters to the GPU op FIFO.
package gpu_op_pkg;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [11:0] arg;
  } gpu_op_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of mask at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);

  localparam int unsigned IW = $clog2(N);

  int unsigned j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && mask[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter feeding the GPU op FIFO; a requester keeps ownership
// until it sends an op marked last, so multi-op sequences stay atomic.
module gpu_op_arbiter
  import gpu_op_pkg::*;
  import gpu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  gpu_op_t [N_REQ-1:0]      req_op,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output gpu_op_t                  op,
  output logic                     op_wr_en,
  input  logic                     op_full,
  output logic                     locked,
  output logic [$clog2(N_REQ)-1:0] owner
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic [IW-1:0] acc_idx_c;
  logic          can_accept_c;
  logic          accept_c;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .mask  (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The pending write strobe blocks accept, giving one op per two cycles.
  assign can_accept_c = ce && !op_full && !op_wr_en && !rst;

  always_comb begin
    req_ready = '0;
    if (can_accept_c) begin
      if (state == IDLE) begin
        if (pick_found) req_ready[pick_idx] = 1'b1;
      end else begin
        req_ready[owner] = req_valid[owner];
      end
    end
  end

  assign accept_c  = |(req_ready & req_valid);
  assign acc_idx_c = (state == LOCKED) ? owner : pick_idx;
  assign locked    = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      op       <= '0;
      op_wr_en <= 1'b0;
    end else if (ce) begin
      op_wr_en <= accept_c;
      if (accept_c) begin
        op    <= req_op[acc_idx_c];
        owner <= acc_idx_c;
        if (req_last[acc_idx_c]) begin
          state  <= IDLE;
          rr_ptr <= (acc_idx_c == IW'(N_REQ - 1)) ? '0 : acc_idx_c + IW'(1);
        end else begin
          state <= LOCKED;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Directed bench for gpu_op_arbiter with a FIFO-side scoreboard on write strobes.
module tb_gpu_op_arbiter;
  import gpu_op_pkg::*;

  typedef struct packed {
    gpu_op_t op;
    logic    last;
  } src_t;

  typedef struct packed {
    gpu_op_t op;
    logic    src;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            ce;
  gpu_op_t [1:0]   req_op;
  logic [1:0]      req_valid;
  logic [1:0]      req_last;
  logic [1:0]      req_ready;
  gpu_op_t         op;
  logic            op_wr_en;
  logic            op_full;
  logic            locked;
  logic [0:0]      owner;

  int checks;
  int failures;

  exp_t exp_q[$];
  src_t src_q0[$];
  src_t src_q1[$];

  gpu_op_arbiter #(.N_REQ(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_op    (req_op),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .op        (op),
    .op_wr_en  (op_wr_en),
    .op_full   (op_full),
    .locked    (locked),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  function automatic gpu_op_t mk(input int s, input int n);
    gpu_op_t r;
    r.opcode = 4'(s + 1);
    r.arg    = 12'(n);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input gpu_op_t o, input logic s);
    exp_t e;
    e.op  = o;
    e.src = s;
    exp_q.push_back(e);
  endtask

  task automatic push_src(input int s, input gpu_op_t o, input logic l);
    src_t v;
    v.op   = o;
    v.last = l;
    if (s == 0) src_q0.push_back(v);
    else        src_q1.push_back(v);
  endtask

  // Presents queued ops per requester; after each accept checks owner and lock state.
  task automatic drive(input int max_cyc);
    int         cyc;
    logic [1:0] acc;
    logic [1:0] lst;
    cyc = 0;
    while ((src_q0.size() > 0 || src_q1.size() > 0) && cyc < max_cyc) begin
      req_valid[0] = (src_q0.size() > 0);
      req_valid[1] = (src_q1.size() > 0);
      if (src_q0.size() > 0) begin
        req_op[0]   = src_q0[0].op;
        req_last[0] = src_q0[0].last;
      end
      if (src_q1.size() > 0) begin
        req_op[1]   = src_q1[0].op;
        req_last[1] = src_q1[0].last;
      end
      #1;
      acc = req_ready & req_valid;
      lst = req_last;
      @(posedge clk);
      #1;
      cyc++;
      if (acc[0]) begin
        void'(src_q0.pop_front());
        chk("acc0_owner", 32'(owner), 32'd0);
        chk("acc0_locked", 32'(locked), 32'(!lst[0]));
      end
      if (acc[1]) begin
        void'(src_q1.pop_front());
        chk("acc1_owner", 32'(owner), 32'd1);
        chk("acc1_locked", 32'(locked), 32'(!lst[1]));
      end
    end
    req_valid = '0;
    if (src_q0.size() > 0 || src_q1.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drive_timeout: pending %0d/%0d after %0d cycles",
               src_q0.size(), src_q1.size(), max_cyc);
      src_q0.delete();
      src_q1.delete();
    end
  endtask

  // FIFO-side monitor: a write lands at the next rising edge when ce and op_wr_en are high.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ce && op_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fifo_write: unexpected write op=%0h owner=%0d expected none", op, owner);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_op", 32'(op), 32'(e.op));
        chk("fifo_owner", 32'(owner), 32'(e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    ce        = 1'b1;
    op_full   = 1'b0;
    req_op    = '0;
    req_valid = 2'b11;
    req_last  = 2'b00;
    checks    = 0;
    failures  = 0;

    // Reset state with requesters valid.
    tick();
    tick();
    chk("rst_op", 32'(op), 32'd0);
    chk("rst_wr_en", 32'(op_wr_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    tick();

    // Alternating single-op grants, strobes two cycles apart.
    req_op[0] = mk(0, 1);
    req_op[1] = mk(1, 1);
    req_last  = 2'b11;
    req_valid = 2'b11;
    push_exp(mk(0, 1), 1'b0);
    push_exp(mk(1, 1), 1'b1);
    push_exp(mk(0, 1), 1'b0);
    push_exp(mk(1, 1), 1'b1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("alt_wr_en", 32'(op_wr_en), 32'((k % 2) == 0));
    end
    req_valid = '0;
    tick();

    // Atomic three-op sequence from req0 while req1 waits.
    push_src(0, mk(0, 11), 1'b0);
    push_src(0, mk(0, 12), 1'b0);
    push_src(0, mk(0, 13), 1'b1);
    push_src(1, mk(1, 21), 1'b1);
    push_exp(mk(0, 11), 1'b0);
    push_exp(mk(0, 12), 1'b0);
    push_exp(mk(0, 13), 1'b1 ^ 1'b1);
    push_exp(mk(1, 21), 1'b1);
    drive(40);
    tick();

    // FIFO full while locked to req1.
    push_src(1, mk(1, 31), 1'b0);
    push_exp(mk(1, 31), 1'b1);
    drive(10);
    tick();
    op_full   = 1'b1;
    req_op[0] = mk(0, 32);
    req_op[1] = mk(1, 32);
    req_last  = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("full_ready", 32'(req_ready), 32'd0);
      tick();
      chk("full_wr_en", 32'(op_wr_en), 32'd0);
      chk("full_owner", 32'(owner), 32'd1);
      chk("full_locked", 32'(locked), 32'd1);
    end
    op_full = 1'b0;
    #1;
    chk("unfull_ready", 32'(req_ready), 32'h2);
    push_src(1, mk(1, 32), 1'b1);
    push_src(0, mk(0, 32), 1'b1);
    push_exp(mk(1, 32), 1'b1);
    push_exp(mk(0, 32), 1'b0);
    drive(20);
    tick();

    // Clock enable dropped during a write strobe.
    req_op[0] = mk(0, 41);
    req_last  = 2'b11;
    req_valid = 2'b01;
    push_exp(mk(0, 41), 1'b0);
    #1;
    chk("ce_ready0", 32'(req_ready), 32'h1);
    tick();
    ce        = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("ce_off_ready", 32'(req_ready), 32'd0);
    tick();
    chk("ce_off_wr_en", 32'(op_wr_en), 32'd1);
    ce        = 1'b1;
    req_valid = 2'b00;
    tick();
    chk("ce_on_wr_en", 32'(op_wr_en), 32'd0);
    tick();

    // Asynchronous reset mid-sequence abandons req1.
    req_op[1] = mk(1, 51);
    req_last  = 2'b00;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    chk("pre_rst_locked", 32'(locked), 32'd1);
    chk("pre_rst_owner", 32'(owner), 32'd1);
    #1;
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_owner", 32'(owner), 32'd0);
    chk("arst_wr_en", 32'(op_wr_en), 32'd0);
    chk("arst_op", 32'(op), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 2'b00;
    rst       = 1'b0;
    push_src(0, mk(0, 52), 1'b1);
    push_src(1, mk(1, 52), 1'b1);
    push_exp(mk(0, 52), 1'b0);
    push_exp(mk(1, 52), 1'b1);
    drive(20);
    tick();

    // Only req1 valid after reset; pointer wraps back to req0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_src(1, mk(1, 61), 1'b1);
    push_exp(mk(1, 61), 1'b1);
    drive(10);
    push_src(0, mk(0, 62), 1'b1);
    push_src(1, mk(1, 62), 1'b1);
    push_exp(mk(0, 62), 1'b0);
    push_exp(mk(1, 62), 1'b1);
    drive(20);
    tick();
    tick();
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
